// File: rtl/fpga_stream_source_pkg.sv
// Shared constants for the block-RAM stream source: CSR map, command codes, FSM states, bit positions.
package fpga_stream_source_pkg;

    localparam logic [2:0] CSR_CTRL      = 3'd0;
    localparam logic [2:0] CSR_ADDR      = 3'd1;
    localparam logic [2:0] CSR_WDATA     = 3'd2;
    localparam logic [2:0] CSR_DUMP_BASE = 3'd3;
    localparam logic [2:0] CSR_DUMP_LEN  = 3'd4;
    localparam logic [2:0] CSR_STAT      = 3'd5;
    localparam logic [2:0] CSR_CNT       = 3'd6;
    localparam logic [2:0] CSR_DBG       = 3'd7;

    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_DUMP  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_DUMP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int CTRL_GO_BIT   = 0;
    localparam int CTRL_CLR_BIT  = 31;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;
    localparam int STAT_DONE_BIT = 2;

endpackage

// File: rtl/fpga_stream_source_if.sv
// Avalon-MM CSR slave signals plus the AXI4-Stream master signals of the stream source.
interface fpga_stream_source_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2:0]            avs_address;
    logic                  avs_chipselect;
    logic                  avs_write_n;
    logic [31:0]           avs_writedata;
    logic [31:0]           avs_readdata;
    logic [DATA_WIDTH-1:0] axis_m_tdata;
    logic                  axis_m_tvalid;
    logic                  axis_m_tlast;
    logic                  axis_m_tready;

    // Design side: CSR slave, stream master.
    modport slave (
        input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
        output avs_readdata,
        output axis_m_tdata, axis_m_tvalid, axis_m_tlast,
        input  axis_m_tready
    );

    // Environment side: HPS bridge and stream sink.
    modport master (
        output avs_address, avs_chipselect, avs_write_n, avs_writedata,
        input  avs_readdata,
        input  axis_m_tdata, axis_m_tvalid, axis_m_tlast,
        output axis_m_tready
    );
endinterface

// File: rtl/fss_skid_buf.sv
// Two-entry register slice between the RAM read port and the stream output.
// The producer never pushes into a full slice; it throttles itself with o_count.
module fss_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);
    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign w_pop   = (r_cnt != 2'd0) && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_d0;
    assign o_count = r_cnt;

    // Head entry only moves on a pop or when the slice is empty, so output holds under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_d0 <= i_data;
                    else               r_d1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fpga_stream_source.sv
// CSR-controlled block-RAM source: word read/write from the HPS, and a window dump as one AXI4-Stream packet.
module fpga_stream_source
    import fpga_stream_source_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    fpga_stream_source_if.slave bus
);
    // state    | meaning
    // ST_IDLE  | waiting for GO; RAM writes complete here in one cycle
    // ST_RD    | RAM word fetched, RDATA captured on exit
    // ST_DUMP  | fetching the window from RAM into the skid slice
    // ST_FLUSH | all words fetched, draining until the tlast handshake
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_dump_base;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic [LEN_WIDTH-1:0]  r_dump_len;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic [1:0]            r_cmd;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_done;
    logic                  r_rd_vld;
    logic                  r_rd_last;
    logic [15:0]           r_beats;
    logic [15:0]           r_pkts;
    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_csr_wr;
    logic                  w_go;
    logic                  w_clr;
    cmd_e                  w_cmd;
    logic                  w_idle;
    logic                  w_go_wr;
    logic                  w_go_rd;
    logic                  w_go_dump;
    logic                  w_go_bad;
    logic                  w_pop;
    logic                  w_fetch;
    logic                  w_last_fetch;
    logic [2:0]            w_occ;
    logic [1:0]            w_sb_count;
    logic                  w_sb_valid;
    logic [DATA_WIDTH:0]   w_sb_data;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [31:0]           w_readdata;

    assign w_csr_wr  = bus.avs_chipselect && !bus.avs_write_n;
    assign w_go      = w_csr_wr && (bus.avs_address == CSR_CTRL) && bus.avs_writedata[CTRL_GO_BIT];
    assign w_clr     = w_csr_wr && (bus.avs_address == CSR_CTRL) && bus.avs_writedata[CTRL_CLR_BIT];
    assign w_cmd     = cmd_e'(bus.avs_writedata[2:1]);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_go_wr   = w_go && w_idle && (w_cmd == CMD_WRITE);
    assign w_go_rd   = w_go && w_idle && (w_cmd == CMD_READ);
    assign w_go_dump = w_go && w_idle && (w_cmd == CMD_DUMP) && (r_dump_len != '0);
    assign w_go_bad  = w_go && !(w_go_wr || w_go_rd || w_go_dump);

    // Occupancy the slice will hold after this edge, counting the read already in flight.
    assign w_pop        = w_sb_valid && bus.axis_m_tready;
    assign w_occ        = {1'b0, w_sb_count} + {2'b00, r_rd_vld} - {2'b00, w_pop};
    assign w_fetch      = (r_state == ST_DUMP) && (w_occ <= 3'd1);
    assign w_last_fetch = w_fetch && (r_remain == LEN_WIDTH'(1));
    assign w_raddr      = w_idle ? r_addr : r_ptr;

    assign bus.axis_m_tvalid = w_sb_valid;
    assign bus.axis_m_tdata  = w_sb_data[DATA_WIDTH-1:0];
    assign bus.axis_m_tlast  = w_sb_valid && w_sb_data[DATA_WIDTH];
    assign bus.avs_readdata  = w_readdata;

    // Simple dual-port RAM: CSR write port, single read port shared by word reads and the dump.
    always_ff @(posedge clk) begin
        if (w_go_wr) r_mem[r_addr] <= r_wdata;
        if (w_go_rd || w_fetch) r_ram_q <= r_mem[w_raddr];
    end

    // Writable CSRs; operations latch these on GO so later writes never disturb them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd       <= 2'b00;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_dump_base <= '0;
            r_dump_len  <= '0;
        end else if (w_csr_wr) begin
            case (bus.avs_address)
                CSR_CTRL:      r_cmd       <= bus.avs_writedata[2:1];
                CSR_ADDR:      r_addr      <= bus.avs_writedata[ADDR_WIDTH-1:0];
                CSR_WDATA:     r_wdata     <= bus.avs_writedata[DATA_WIDTH-1:0];
                CSR_DUMP_BASE: r_dump_base <= bus.avs_writedata[ADDR_WIDTH-1:0];
                CSR_DUMP_LEN:  r_dump_len  <= bus.avs_writedata[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Dump read pointer wraps naturally at DEPTH; the last fetch tags its word for tlast.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_remain  <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            if (w_go_dump) begin
                r_ptr    <= r_dump_base;
                r_remain <= r_dump_len;
            end else if (w_fetch) begin
                r_ptr    <= r_ptr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
            r_rd_vld  <= w_fetch;
            r_rd_last <= w_last_fetch;
        end
    end

    // Control FSM with registered BUSY/ERR/DONE/RDATA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_go_bad) r_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_wr) begin
                        r_err  <= 1'b0;
                        r_done <= 1'b1;
                    end else if (w_go_rd) begin
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RD;
                    end else if (w_go_dump) begin
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DUMP;
                    end
                end
                ST_RD: begin
                    r_rdata <= r_ram_q;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_DUMP: begin
                    if (w_last_fetch) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_pop && bus.axis_m_tlast) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Beat and packet counters; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beats <= 16'd0;
            r_pkts  <= 16'd0;
        end else if (w_clr) begin
            r_beats <= 16'd0;
            r_pkts  <= 16'd0;
        end else begin
            if (w_pop) r_beats <= r_beats + 16'd1;
            if (w_pop && bus.axis_m_tlast) r_pkts <= r_pkts + 16'd1;
        end
    end

    // Zero-wait-state CSR read mux.
    always_comb begin
        w_readdata = '0;
        case (bus.avs_address)
            CSR_CTRL:      w_readdata[2:1] = r_cmd;
            CSR_ADDR:      w_readdata[ADDR_WIDTH-1:0] = r_addr;
            CSR_WDATA:     w_readdata[DATA_WIDTH-1:0] = r_wdata;
            CSR_DUMP_BASE: w_readdata[ADDR_WIDTH-1:0] = r_dump_base;
            CSR_DUMP_LEN:  w_readdata[LEN_WIDTH-1:0]  = r_dump_len;
            CSR_STAT: begin
                w_readdata[STAT_BUSY_BIT] = r_busy;
                w_readdata[STAT_ERR_BIT]  = r_err;
                w_readdata[STAT_DONE_BIT] = r_done;
                w_readdata[31:16]         = 16'(r_rdata);
            end
            CSR_CNT:       w_readdata = {r_pkts, r_beats};
            CSR_DBG: begin
                w_readdata[ADDR_WIDTH-1:0] = r_ptr;
                w_readdata[29:28]          = r_state;
            end
            default: ;
        endcase
    end

    fss_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_rd_vld),
        .i_data  ({r_rd_last, r_ram_q}),
        .i_ready (bus.axis_m_tready),
        .o_valid (w_sb_valid),
        .o_data  (w_sb_data),
        .o_count (w_sb_count)
    );
endmodule

// File: tb/tb_fpga_stream_source.sv
// Directed + randomized bench for fpga_stream_source against a window/array model of the RAM.
module tb_fpga_stream_source;
    import fpga_stream_source_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int LW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fpga_stream_source_if #(.DATA_WIDTH(DW)) bif();

    fpga_stream_source #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mem_m [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
        bif.avs_address    = a;
        bif.avs_chipselect = 1'b1;
        bif.avs_write_n    = 1'b0;
        bif.avs_writedata  = d;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        drive_wr(a, d);
        @(posedge clk); #1;
        bif.avs_chipselect = 1'b0;
        bif.avs_write_n    = 1'b1;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        bif.avs_address = a;
        #1;
        d = bif.avs_readdata;
    endtask

    task automatic ram_write(input int a, input logic [DW-1:0] d);
        csr_write(CSR_ADDR, 32'(a));
        csr_write(CSR_WDATA, 32'(d));
        csr_write(CSR_CTRL, 32'h3);
        mem_m[a] = d;
    endtask

    // mode 0: plain; mode 1: rejected GOs and a DUMP_LEN rewrite mid-stream; mode 2: CLR_CNT on a handshake cycle
    task automatic run_dump(input int base, input int len, input int pct, input int mode,
                            input logic [31:0] exp_cnt, input logic [2:0] exp_stat, input string tag);
        int c, got, first_c, last_c, bad_data, bad_last, bad_stable, n_last, budget;
        logic v, l, rdy, pv_stall, pl;
        logic [DW-1:0] d, pd;
        logic [31:0] rd;
        csr_write(CSR_DUMP_BASE, 32'(base));
        csr_write(CSR_DUMP_LEN, 32'(len));
        csr_write(CSR_CTRL, 32'h5);
        c = 0; got = 0; first_c = -1; last_c = -1;
        bad_data = 0; bad_last = 0; bad_stable = 0; n_last = 0;
        pv_stall = 1'b0; pd = '0; pl = 1'b0;
        budget = len * 20 + 50;
        while (got < len && c < budget) begin
            bif.avs_chipselect = 1'b0;
            bif.avs_write_n    = 1'b1;
            v = bif.axis_m_tvalid;
            d = bif.axis_m_tdata;
            l = bif.axis_m_tlast;
            if (pv_stall && (!v || d !== pd || l !== pl)) bad_stable++;
            if (mode == 2 && c == 6) begin
                csr_read(CSR_CNT, rd);
                check({tag, "_cnt_after_clr"}, rd, 32'h0);
            end
            if (mode == 1 && c == 20) drive_wr(CSR_CTRL, 32'h5);
            if (mode == 1 && c == 30) drive_wr(CSR_DUMP_LEN, 32'h5);
            if (mode == 1 && c == 40) drive_wr(CSR_CTRL, 32'h3);
            if (mode == 2 && c == 5)  drive_wr(CSR_CTRL, 32'h8000_0000);
            rdy = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
            bif.axis_m_tready = rdy;
            if (v && rdy) begin
                if (d !== mem_m[(base + got) % DEPTH]) bad_data++;
                if (l !== (got == len - 1)) bad_last++;
                if (l) n_last++;
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            pv_stall = v && !rdy;
            pd = d;
            pl = l;
            @(posedge clk); #1;
            c++;
        end
        bif.axis_m_tready  = 1'b0;
        bif.avs_chipselect = 1'b0;
        bif.avs_write_n    = 1'b1;
        check({tag, "_beats"}, 32'(got), 32'(len));
        check({tag, "_data_errs"}, 32'(bad_data), 32'h0);
        check({tag, "_tlast_errs"}, 32'(bad_last), 32'h0);
        check({tag, "_tlast_count"}, 32'(n_last), 32'h1);
        check({tag, "_unstable"}, 32'(bad_stable), 32'h0);
        if (pct >= 100) begin
            check({tag, "_first_cycle"}, 32'(first_c), 32'h2);
            check({tag, "_span"}, 32'(last_c - first_c), 32'(len - 1));
        end
        for (int i = 0; i < 8; i++) begin
            csr_read(CSR_STAT, rd);
            if (rd[0] == 1'b0) break;
            @(posedge clk); #1;
        end
        check({tag, "_stat"}, {29'h0, rd[2:0]}, {29'h0, exp_stat});
        check({tag, "_tvalid_after"}, {31'h0, bif.axis_m_tvalid}, 32'h0);
        csr_read(CSR_CNT, rd);
        check({tag, "_cnt"}, rd, exp_cnt);
    endtask

    initial begin
        logic [31:0] rd;
        bif.avs_address    = 3'd0;
        bif.avs_chipselect = 1'b0;
        bif.avs_write_n    = 1'b1;
        bif.avs_writedata  = 32'h0;
        bif.axis_m_tready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), rd);
            check($sformatf("reset_csr%0d", a), rd, 32'h0);
        end
        check("reset_tvalid", {31'h0, bif.axis_m_tvalid}, 32'h0);
        check("reset_tlast", {31'h0, bif.axis_m_tlast}, 32'h0);
        check("reset_tdata", 32'(bif.axis_m_tdata), 32'h0);

        // Word write then read back
        ram_write(32'h010, 8'hA5);
        csr_read(CSR_STAT, rd);
        check("write_stat", rd, 32'h0000_0004);
        csr_write(CSR_ADDR, 32'h010);
        csr_write(CSR_CTRL, 32'h1);
        csr_read(CSR_STAT, rd);
        check("read_busy", rd, 32'h0000_0001);
        @(posedge clk); #1;
        csr_read(CSR_STAT, rd);
        check("read_stat", rd, 32'h00A5_0004);

        // Fill the windows used by the dumps
        for (int a = 0; a < 8; a++) ram_write(a, 8'($urandom_range(255)));
        ram_write(DEPTH - 2, 8'($urandom_range(255)));
        ram_write(DEPTH - 1, 8'($urandom_range(255)));
        for (int a = 100; a < 400; a++) ram_write(a, 8'($urandom_range(255)));

        run_dump(0, 4, 100, 0, 32'h0001_0004, 3'b100, "dump_base0");
        run_dump(DEPTH - 2, 4, 100, 0, 32'h0002_0008, 3'b100, "dump_wrap");
        run_dump(100, 300, 50, 1, 32'h0003_0134, 3'b110, "dump_bp");
        csr_read(CSR_DUMP_LEN, rd);
        check("len_rewritten", rd, 32'h5);

        // Error paths: accepted GO clears ERR, LEN=0 and CMD=11 set it
        csr_write(CSR_CTRL, 32'h1);
        @(posedge clk); #1;
        csr_read(CSR_STAT, rd);
        check("err_cleared", {29'h0, rd[2:0]}, 32'h4);
        csr_write(CSR_DUMP_LEN, 32'h0);
        csr_write(CSR_CTRL, 32'h5);
        repeat (3) begin @(posedge clk); #1; end
        csr_read(CSR_STAT, rd);
        check("len0_err", {29'h0, rd[2:0]}, 32'h6);
        check("len0_tvalid", {31'h0, bif.axis_m_tvalid}, 32'h0);
        csr_read(CSR_DBG, rd);
        check("len0_state", {30'h0, rd[29:28]}, 32'h0);
        csr_write(CSR_CTRL, 32'h1);
        @(posedge clk); #1;
        csr_write(CSR_CTRL, 32'h7);
        csr_read(CSR_STAT, rd);
        check("rsvd_err", {29'h0, rd[2:0]}, 32'h6);

        // Counter clear colliding with a handshake
        run_dump(100, 10, 100, 2, 32'h0001_0006, 3'b100, "dump_clr");

        // Reset in the middle of a stalled dump
        csr_write(CSR_DUMP_BASE, 32'd100);
        csr_write(CSR_DUMP_LEN, 32'd300);
        csr_write(CSR_CTRL, 32'h5);
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_tvalid", {31'h0, bif.axis_m_tvalid}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_tvalid", {31'h0, bif.axis_m_tvalid}, 32'h0);
        check("rst_tlast", {31'h0, bif.axis_m_tlast}, 32'h0);
        check("rst_tdata", 32'(bif.axis_m_tdata), 32'h0);
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), rd);
            check($sformatf("rst_csr%0d", a), rd, 32'h0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_dump(0, 4, 100, 0, 32'h0001_0004, 3'b100, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
